// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// One access at a time: IDLE -> ISSUE -> (CAPTURE for reads) -> ACK -> IDLE.
module ram_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          ReqA,
  input  logic          ReqB,
  input  logic          WeA,
  input  logic          WeB,
  input  logic [AW-1:0] AddrA,
  input  logic [AW-1:0] AddrB,
  input  logic [DW-1:0] DinA,
  input  logic [DW-1:0] DinB,
  output logic          AckA,
  output logic          AckB,
  output logic [DW-1:0] DoutA,
  output logic [DW-1:0] DoutB,
  output logic          Busy,
  output logic          RamCS,
  output logic          RamWE,
  output logic [AW-1:0] RamAddr,
  output logic [DW-1:0] RamDataIn,
  input  logic [DW-1:0] RamDataOut,
  output logic [1:0]    DbgState
);

  // Handshake: a requester raises Req with We/Addr/Din and holds them until
  // it sees its Ack; Req is dropped on the edge that ends the Ack cycle.

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t        state, next_state;
  logic          last_gnt;   // 0 = A, 1 = B; also the id of the current grant
  logic          lat_we;
  logic          win_b;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_din;
  logic          any_req;

  assign DbgState = state;
  assign any_req  = ReqA | ReqB;

  always_comb begin
    win_b      = ReqB;
    next_state = state;
    if (ReqA && ReqB) win_b = ~last_gnt;
    win_we   = win_b ? WeB   : WeA;
    win_addr = win_b ? AddrB : AddrA;
    win_din  = win_b ? DinB  : DinA;
    case (state)
      IDLE:    if (any_req) next_state = ISSUE;
      ISSUE:   next_state = lat_we ? ACK : CAPTURE;
      CAPTURE: next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // All outputs are registered from next_state so reset clears them at once.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      lat_we    <= 1'b0;
      Busy      <= 1'b0;
      RamCS     <= 1'b0;
      RamWE     <= 1'b0;
      RamAddr   <= '0;
      RamDataIn <= '0;
      AckA      <= 1'b0;
      AckB      <= 1'b0;
      DoutA     <= '0;
      DoutB     <= '0;
    end else begin
      state <= next_state;
      Busy  <= (next_state != IDLE);
      RamCS <= (next_state == ISSUE);
      RamWE <= (next_state == ISSUE) && win_we;
      AckA  <= (next_state == ACK) && !last_gnt;
      AckB  <= (next_state == ACK) && last_gnt;
      if (state == IDLE && any_req) begin
        last_gnt  <= win_b;
        lat_we    <= win_we;
        RamAddr   <= win_addr;
        RamDataIn <= win_din;
      end
      if (state == CAPTURE) begin
        if (last_gnt) DoutB <= RamDataOut;
        else          DoutA <= RamDataOut;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, transaction-level reference model,
// directed scenarios followed by randomized request rounds.
module tb_ram_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          ReqA = 1'b0, ReqB = 1'b0, WeA = 1'b0, WeB = 1'b0;
  logic [AW-1:0] AddrA = '0, AddrB = '0;
  logic [DW-1:0] DinA = '0, DinB = '0;
  logic          AckA, AckB, Busy, RamCS, RamWE;
  logic [DW-1:0] DoutA, DoutB, RamDataIn;
  logic [DW-1:0] RamDataOut;
  logic [AW-1:0] RamAddr;
  logic [1:0]    DbgState;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [DW-1:0] m_mem [8];
  logic [DW-1:0] m_dout [2];
  int            m_last;   // 0 = A, 1 = B
  logic [DW-1:0] exp_q [$];

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  ram_arbiter #(.DW(DW), .AW(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqA(ReqA), .ReqB(ReqB), .WeA(WeA), .WeB(WeB),
    .AddrA(AddrA), .AddrB(AddrB), .DinA(DinA), .DinB(DinB),
    .AckA(AckA), .AckB(AckB), .DoutA(DoutA), .DoutB(DoutB),
    .Busy(Busy), .RamCS(RamCS), .RamWE(RamWE),
    .RamAddr(RamAddr), .RamDataIn(RamDataIn), .RamDataOut(RamDataOut),
    .DbgState(DbgState)
  );

  // behavioural synchronous RAM
  logic [DW-1:0] ram_mem [8];
  always @(posedge Clk) begin
    if (RamCS) begin
      if (RamWE) ram_mem[RamAddr] <= RamDataIn;
      else       RamDataOut <= ram_mem[RamAddr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // RAM strobe never asserted in back-to-back cycles; no write enable without select
  logic mon_on = 1'b0;
  logic prev_cs = 1'b0;
  always @(negedge Clk) begin
    if (mon_on) begin
      check("cs_back_to_back", {31'd0, prev_cs & RamCS}, 32'd0);
      check("we_without_cs", {31'd0, RamWE & ~RamCS}, 32'd0);
    end
    prev_cs <= RamCS;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"},   {31'd0, RamCS}, 32'd0);
    check({tag, "_we"},   {31'd0, RamWE}, 32'd0);
    check({tag, "_addr"}, {29'd0, RamAddr}, 32'd0);
    check({tag, "_din"},  {24'd0, RamDataIn}, 32'd0);
    check({tag, "_acka"}, {31'd0, AckA}, 32'd0);
    check({tag, "_ackb"}, {31'd0, AckB}, 32'd0);
    check({tag, "_douta"}, {24'd0, DoutA}, 32'd0);
    check({tag, "_doutb"}, {24'd0, DoutB}, 32'd0);
    check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    ReqA = 1'b0;
    ReqB = 1'b0;
    #1 check_reset_vals("reset");
    @(negedge Clk);
    Rst_n = 1'b1;
    m_last = 1;
    m_dout[0] = '0;
    m_dout[1] = '0;
  endtask

  // ---------------- driver + model ----------------
  // Raises the selected requests together, then checks every following cycle
  // against the timing the grant order implies: write 2 cycles, read 3 cycles
  // from the sampling edge to Ack, one IDLE cycle between transactions.
  task automatic run_round(input bit ra, input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                           input bit rb, input bit wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    int            order [$];
    int            s_cyc [2];
    int            a_cyc [2];
    bit            r_we [2];
    logic [AW-1:0] r_addr [2];
    logic [DW-1:0] r_din [2];
    int            t, id, last_end;
    bit            e_cs, e_we, e_busy;
    bit            e_ack [2];
    r_we[0] = wa; r_addr[0] = aa; r_din[0] = da;
    r_we[1] = wb; r_addr[1] = ab; r_din[1] = db;
    if (ra && rb) order.push_back(m_last == 1 ? 0 : 1);
    else          order.push_back(ra ? 0 : 1);
    if (ra && rb) order.push_back(1 - order[0]);
    t = 1;
    foreach (order[k]) begin
      id = order[k];
      s_cyc[id] = t;
      a_cyc[id] = t - 1 + (r_we[id] ? 2 : 3);
      t = a_cyc[id] + 2;
    end
    last_end = t - 1;
    m_last = order[order.size()-1];

    ReqA = ra; WeA = wa; AddrA = aa; DinA = da;
    ReqB = rb; WeB = wb; AddrB = ab; DinB = db;
    for (int n = 1; n <= last_end; n++) begin
      @(posedge Clk);
      @(negedge Clk);
      e_cs = 0; e_we = 0; e_busy = 0; e_ack[0] = 0; e_ack[1] = 0;
      foreach (order[k]) begin
        id = order[k];
        if (n == s_cyc[id]) begin
          e_cs = 1;
          e_we = r_we[id];
          check("issue_addr", {29'd0, RamAddr}, {29'd0, r_addr[id]});
          if (r_we[id]) check("issue_wdata", {24'd0, RamDataIn}, {24'd0, r_din[id]});
        end
        if (n >= s_cyc[id] && n <= a_cyc[id]) e_busy = 1;
        if (n == a_cyc[id]) begin
          e_ack[id] = 1;
          if (r_we[id]) m_mem[r_addr[id]] = r_din[id];
          else          m_dout[id] = m_mem[r_addr[id]];
        end
      end
      check("ram_cs", {31'd0, RamCS}, {31'd0, e_cs});
      check("ram_we", {31'd0, RamWE}, {31'd0, e_we});
      check("busy", {31'd0, Busy}, {31'd0, e_busy});
      check("ack_a", {31'd0, AckA}, {31'd0, e_ack[0]});
      check("ack_b", {31'd0, AckB}, {31'd0, e_ack[1]});
      check("dout_a", {24'd0, DoutA}, {24'd0, m_dout[0]});
      check("dout_b", {24'd0, DoutB}, {24'd0, m_dout[1]});
      if (e_ack[0]) ReqA = 1'b0;
      if (e_ack[1]) ReqB = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_last = 1;
    m_dout[0] = '0;
    m_dout[1] = '0;
    #1 check_reset_vals("por");
    do_reset();
    mon_on = 1'b1;

    // A writes 30 to 0, then B reads it back
    run_round(1, 1, 3'd0, 8'd30, 0, 0, 3'd0, 8'd0);
    run_round(0, 0, 3'd0, 8'd0, 1, 0, 3'd0, 8'd0);
    check("b_read_30", {24'd0, DoutB}, 32'd30);
    check("a_untouched", {24'd0, DoutA}, 32'd0);

    // fill 0..7 from A, read back from B in order
    for (int i = 0; i < 8; i++) begin
      run_round(1, 1, AW'(i), DW'(30 + i), 0, 0, 3'd0, 8'd0);
      exp_q.push_back(DW'(30 + i));
    end
    for (int i = 0; i < 8; i++) begin
      run_round(0, 0, 3'd0, 8'd0, 1, 0, AW'(i), 8'd0);
      check("seq_read", {24'd0, DoutB}, {24'd0, exp_q.pop_front()});
    end

    // simultaneous requests from reset: A, B, A, B
    do_reset();
    run_round(1, 1, 3'd4, 8'd34, 1, 0, 3'd5, 8'd0);
    run_round(1, 0, 3'd2, 8'd0, 1, 1, 3'd6, 8'd36);
    check("tie_b_read", {24'd0, DoutB}, 32'd35);
    check("tie_a_read", {24'd0, DoutA}, 32'd32);

    // reset pulse while A's write of 41 to addr 1 is in ISSUE
    @(negedge Clk);
    ReqA = 1'b1; WeA = 1'b1; AddrA = 3'd1; DinA = 8'd41;
    @(posedge Clk);
    @(negedge Clk);
    check("abort_in_issue", {31'd0, RamCS}, 32'd1);
    Rst_n = 1'b0;
    ReqA = 1'b0;
    #1 check_reset_vals("mid_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("abort_no_ack", {31'd0, AckA}, 32'd0);
      check("abort_cs_low", {31'd0, RamCS}, 32'd0);
    end
    Rst_n = 1'b1;
    m_last = 1;
    m_dout[0] = '0;
    m_dout[1] = '0;
    run_round(0, 0, 3'd0, 8'd0, 1, 0, 3'd1, 8'd0);
    check("abort_kept_31", {24'd0, DoutB}, 32'd31);

    // randomized rounds
    for (int r = 0; r < 200; r++) begin
      bit ra, rb;
      int sel;
      sel = $urandom_range(0, 2);
      ra = (sel != 1);
      rb = (sel != 0);
      run_round(ra, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                rb, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge Clk);
    end

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DW, default 8, data width of the shared RAM and of both requester data ports.
REQ-002 Parameter AW, default 3, address width of the shared RAM (8 locations).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Clk  input  1  rising-edge clock; all state updates on posedge Clk.
REQ-005 Rst_n  input  1  asynchronous active-low reset.
REQ-006 ReqA / ReqB  input  1  access request from requester A / B.
REQ-007 WeA / WeB  input  1  1 = write, 0 = read; valid while Req is high.
REQ-008 AddrA / AddrB  input  AW  target address; valid while Req is high.
REQ-009 DinA / DinB  input  DW  write data; valid while Req is high.
REQ-010 AckA / AckB  output  1  one-cycle completion pulse to requester A / B.
REQ-011 DoutA / DoutB  output  DW  read data returned to A / B; registered.
REQ-012 Busy  output  1  high whenever FSM is not IDLE.
REQ-013 RamCS / RamWE  output  1  chip-select / write-enable to the RAM (RAM samples on posedge Clk).
REQ-014 RamAddr  output  AW;  RamDataIn  output  DW  address and write data to the RAM.
REQ-015 RamDataOut  input  DW  RAM registered read data; valid in the cycle after a CS=1, WE=0 cycle.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, CAPTURE, ACK; encoding free.
REQ-017 IDLE: if ReqA or ReqB sampled high at posedge, latch winner id, We, Addr, Din; go to ISSUE; else stay IDLE.
REQ-018 Arbitration SHALL be round-robin on a 1-bit LastGnt: single requester wins; both high -> requester other than LastGnt wins.
REQ-019 LastGnt SHALL update to the winner's id on the transition out of IDLE.
REQ-020 ISSUE: RamCS=1, RamWE=latched We, RamAddr/RamDataIn=latched values, exactly one cycle; write -> ACK, read -> CAPTURE.
REQ-021 CAPTURE: RamCS=0; on the posedge ending CAPTURE, RamDataOut SHALL be loaded into Dout of the granted requester only; -> ACK.
REQ-022 ACK: Ack of granted requester high for exactly one cycle, other Ack low; -> IDLE.
REQ-023 Latency from Req sampled in IDLE to Ack high: write 2 cycles, read 3 cycles.
REQ-024 Outside ISSUE, RamCS=0 and RamWE=0; RamAddr/RamDataIn hold latched values.
REQ-025 DoutA/DoutB SHALL hold their value until the next completed read for that requester; writes do not alter them.
REQ-026 Requester SHALL hold Req/We/Addr/Din stable until Ack and drop Req on the edge ending Ack; Req still high in the following IDLE is a new request.
REQ-027 Inputs of the losing/non-granted requester SHALL be ignored until the FSM returns to IDLE; its pending Req is not lost, only deferred.
REQ-028 Busy SHALL equal (state != IDLE), registered.

Reset
REQ-029 Rst_n low SHALL asynchronously force: state IDLE, LastGnt=B (A wins first tie), RamCS=0, RamWE=0, RamAddr=0, RamDataIn=0, AckA=AckB=0, DoutA=DoutB=0, Busy=0.
REQ-030 Reset during ISSUE SHALL drop RamCS before the next edge so no write is committed; no Ack is issued for the aborted access.
REQ-031 After Rst_n deasserts, the first posedge SHALL evaluate requests in IDLE.

Verification
REQ-032 A writes 30 to addr 0 (WeA=1) -> RamCS=1,RamWE=1,RamAddr=0,RamDataIn=30 for one cycle; AckA 2 cycles after Req sample; DoutA unchanged (0).
REQ-033 B reads addr 0 after REQ-032 -> AckB 3 cycles after Req sample, DoutB=30; DoutA still 0.
REQ-034 ReqA and ReqB high together from reset, both held -> grant order A, B, A, B; each Ack 1 cycle, no overlap.
REQ-035 A writes 8 locations 0..7 with 30..37, B reads 0..7 -> DoutB sequence 30..37, RamCS never high in two consecutive cycles.
REQ-036 Rst_n pulsed low during ISSUE of A write 41 to addr 1 (prior content 31) -> no AckA; subsequent read of addr 1 returns 31; all outputs at REQ-029 values during reset.
